// File: rtl/mioc_pulse_ctrl_if.sv
// Requester, pulse and readback bundle for the MIOC set/reset pulse controller.
// The master side drives requests and readback; the slave is the controller.
interface mioc_pulse_ctrl_if #(
    parameter int CHW = 2,
    parameter int NCH = 4
);
    logic           req_a;
    logic           req_b;
    logic           op_a;
    logic           op_b;
    logic [CHW-1:0] ch_a;
    logic [CHW-1:0] ch_b;
    logic [NCH-1:0] q_fb;
    logic           gnt_a;
    logic           gnt_b;
    logic [NCH-1:0] set_p;
    logic [NCH-1:0] rst_p;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output req_a, req_b, op_a, op_b, ch_a, ch_b, q_fb,
        input  gnt_a, gnt_b, set_p, rst_p, busy, done, err
    );

    modport slave (
        input  req_a, req_b, op_a, op_b, ch_a, ch_b, q_fb,
        output gnt_a, gnt_b, set_p, rst_p, busy, done, err
    );
endinterface

// File: rtl/mioc_pulse_ctrl.sv
// Round-robin arbiter and pulse sequencer driving MIOC set/reset flops,
// with a fixed settle gap and a one-cycle readback check per operation.
module mioc_pulse_ctrl #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int PW  = 2,
    parameter int GAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mioc_pulse_ctrl_if.slave  io
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_CHECK
    } state_e;

    localparam logic [3:0] PW_M1  = 4'(PW - 1);
    localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic           last_b_q;
    logic           op_q;
    logic [CHW-1:0] ch_q;
    logic           gnt_a_q;
    logic           gnt_b_q;
    logic [NCH-1:0] set_q;
    logic [NCH-1:0] rst_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           win_b_d;
    logic           op_d;
    logic [CHW-1:0] ch_d;
    logic [NCH-1:0] sel_d;
    logic           err_d;

    // On a tie the requester not granted last wins.
    always_comb begin
        win_b_d = io.req_b;
        if (io.req_a && io.req_b) begin
            win_b_d = ~last_b_q;
        end
        op_d  = win_b_d ? io.op_b : io.op_a;
        ch_d  = win_b_d ? io.ch_b : io.ch_a;
        sel_d = '0;
        sel_d[ch_d] = 1'b1;
        err_d = io.q_fb[ch_q] != op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            op_q     <= 1'b0;
            ch_q     <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            set_q    <= '0;
            rst_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (io.req_a || io.req_b) begin
                        state_q  <= S_PULSE;
                        cnt_q    <= PW_M1;
                        last_b_q <= win_b_d;
                        op_q     <= op_d;
                        ch_q     <= ch_d;
                        gnt_a_q  <= ~win_b_d;
                        gnt_b_q  <= win_b_d;
                        busy_q   <= 1'b1;
                        set_q    <= op_d ? sel_d : '0;
                        rst_q    <= op_d ? '0 : sel_d;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        set_q <= '0;
                        rst_q <= '0;
                        if (GAP == 0) begin
                            state_q <= S_CHECK;
                            done_q  <= 1'b1;
                            err_q   <= err_d;
                        end else begin
                            state_q <= S_GAP;
                            cnt_q   <= GAP_M1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CHECK;
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_CHECK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io.gnt_a = gnt_a_q;
    assign io.gnt_b = gnt_b_q;
    assign io.set_p = set_q;
    assign io.rst_p = rst_q;
    assign io.busy  = busy_q;
    assign io.done  = done_q;
    assign io.err   = err_q;
endmodule

// File: tb/tb_mioc_pulse_ctrl.sv
// Randomized bench for two controller instances (PW=2/GAP=1 and PW=1/GAP=0)
// against a transaction-level timing model, with random mid-operation resets.
module tb_mioc_pulse_ctrl;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mioc_pulse_ctrl_if #(.CHW(2), .NCH(4)) if0 ();
    mioc_pulse_ctrl_if #(.CHW(2), .NCH(4)) if1 ();

    mioc_pulse_ctrl #(.NCH(4), .CHW(2), .PW(2), .GAP(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if0.slave)
    );

    mioc_pulse_ctrl #(.NCH(4), .CHW(2), .PW(1), .GAP(0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if1.slave)
    );

    logic       ra[2], rb[2], oa[2], ob[2];
    logic [1:0] ca[2], cb[2];
    logic [3:0] qf[2];

    assign if0.req_a = ra[0];
    assign if0.req_b = rb[0];
    assign if0.op_a  = oa[0];
    assign if0.op_b  = ob[0];
    assign if0.ch_a  = ca[0];
    assign if0.ch_b  = cb[0];
    assign if0.q_fb  = qf[0];
    assign if1.req_a = ra[1];
    assign if1.req_b = rb[1];
    assign if1.op_a  = oa[1];
    assign if1.op_b  = ob[1];
    assign if1.ch_a  = ca[1];
    assign if1.ch_b  = cb[1];
    assign if1.q_fb  = qf[1];

    int pw[2];
    int gp[2];
    assign pw[0] = 2;
    assign pw[1] = 1;
    assign gp[0] = 1;
    assign gp[1] = 0;

    int nvec;
    int nbad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: an operation occupies PW+GAP+1 busy cycles starting with
    // the grant cycle; pulses fill the first PW, done marks the last.
    int         rem[2], age[2], mch[2];
    bit         lastb[2], mop[2];
    bit         ega[2], egb[2], ebusy[2], edone[2], eerr[2];
    logic [3:0] eset[2], erst[2];

    task automatic mreset(input int i);
        rem[i]   = 0;
        age[i]   = 0;
        lastb[i] = 1'b1;
        ega[i]   = 1'b0;
        egb[i]   = 1'b0;
        ebusy[i] = 1'b0;
        edone[i] = 1'b0;
        eerr[i]  = 1'b0;
        eset[i]  = '0;
        erst[i]  = '0;
    endtask

    task automatic mstep(input int i);
        bit         wb;
        logic [3:0] one;
        one    = 4'd1;
        ega[i] = 1'b0;
        egb[i] = 1'b0;
        if (rem[i] == 0) begin
            if (ra[i] || rb[i]) begin
                wb       = (ra[i] && rb[i]) ? !lastb[i] : rb[i];
                lastb[i] = wb;
                mop[i]   = wb ? ob[i] : oa[i];
                mch[i]   = wb ? int'(cb[i]) : int'(ca[i]);
                rem[i]   = pw[i] + gp[i] + 1;
                age[i]   = 0;
                ega[i]   = !wb;
                egb[i]   = wb;
            end
        end else begin
            rem[i]--;
            age[i]++;
        end
        ebusy[i] = rem[i] > 0;
        eset[i]  = '0;
        erst[i]  = '0;
        if (ebusy[i] && age[i] < pw[i]) begin
            if (mop[i]) eset[i] = one << mch[i];
            else        erst[i] = one << mch[i];
        end
        edone[i] = ebusy[i] && (age[i] == pw[i] + gp[i]);
        eerr[i]  = edone[i] && (qf[i][mch[i]] != mop[i]);
    endtask

    task automatic cmp(input int i);
        logic       ga, gb, bz, dn, er;
        logic [3:0] sp, rp;
        ga = (i == 0) ? if0.gnt_a : if1.gnt_a;
        gb = (i == 0) ? if0.gnt_b : if1.gnt_b;
        sp = (i == 0) ? if0.set_p : if1.set_p;
        rp = (i == 0) ? if0.rst_p : if1.rst_p;
        bz = (i == 0) ? if0.busy  : if1.busy;
        dn = (i == 0) ? if0.done  : if1.done;
        er = (i == 0) ? if0.err   : if1.err;
        chk($sformatf("u%0d.gnt_a", i), 32'(ga), 32'(ega[i]));
        chk($sformatf("u%0d.gnt_b", i), 32'(gb), 32'(egb[i]));
        chk($sformatf("u%0d.set_p", i), 32'(sp), 32'(eset[i]));
        chk($sformatf("u%0d.rst_p", i), 32'(rp), 32'(erst[i]));
        chk($sformatf("u%0d.busy", i),  32'(bz), 32'(ebusy[i]));
        chk($sformatf("u%0d.done", i),  32'(dn), 32'(edone[i]));
        chk($sformatf("u%0d.err", i),   32'(er), 32'(eerr[i]));
    endtask

    // A requester holds its request until granted, then may re-request.
    task automatic drive(input int i);
        if (ega[i] || !ra[i]) begin
            ra[i] = ($urandom_range(0, 2) == 0);
            oa[i] = 1'($urandom_range(0, 1));
            ca[i] = 2'($urandom_range(0, 3));
        end
        if (egb[i] || !rb[i]) begin
            rb[i] = ($urandom_range(0, 2) == 0);
            ob[i] = 1'($urandom_range(0, 1));
            cb[i] = 2'($urandom_range(0, 3));
        end
        qf[i] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        nvec  = 0;
        nbad  = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mreset(i);
            ra[i] = 1'b1;
            rb[i] = 1'b1;
            oa[i] = 1'($urandom_range(0, 1));
            ob[i] = 1'($urandom_range(0, 1));
            ca[i] = 2'($urandom_range(0, 3));
            cb[i] = 2'($urandom_range(0, 3));
            qf[i] = 4'($urandom_range(0, 15));
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) cmp(i);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c > 0) begin
                for (int i = 0; i < 2; i++) drive(i);
            end
            rst_n = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 2; i++) mstep(i);
            #1;
            for (int i = 0; i < 2; i++) cmp(i);
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    mreset(i);
                    cmp(i);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
